// File: rtl/change_dispenser.sv
// change_dispenser: coin-hopper driver for the change path.
// Pays out a change amount (1-jiao units) greedily: 1 yuan (10), 5 jiao (5),
// then 1 jiao (1). Each coin is a fixed-width one-hot eject pulse followed by
// a wait for the hopper's coin-out acknowledge.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous reset, active-high
//   start_i     one-cycle payout request, amount_i sampled on the same edge
//   amount_i    change to pay, 1-jiao units
//   coin_ack_i  hopper sensor, one-cycle pulse per coin ejected
//   eject_o     one-hot eject: bit0 1 jiao, bit1 5 jiao, bit2 1 yuan
//   busy_o      payout in progress
//   done_o      one-cycle pulse on payout completion
//   err_o       hopper timeout, sticky until the next accepted start
//   remain_o    amount still owed
//   cnt_*_o     coins dispensed per denomination in the current payout
//
// All outputs are registered from the current state and datapath, so every
// output trails the internal state by one clock.
//
// state    | meaning
// IDLE     | waiting for start_i
// SELECT   | pick the largest coin not exceeding the remainder
// EJECT    | drive the eject pulse for PULSE_CYC cycles
// WAIT_ACK | wait for the hopper acknowledge, bounded by ACK_TIMEOUT
// DONE     | payout complete, pulse done_o
// ERR      | hopper timeout, raise err_o

module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             coin_ack_i,
    output logic [2:0]       eject_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AMT_W-1:0] remain_o,
    output logic [4:0]       cnt_yuan_o,
    output logic [4:0]       cnt_5j_o,
    output logic [4:0]       cnt_1j_o
);

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        WAIT_ACK,
        DONE,
        ERR
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem, rem_nxt, rem_sub, coin_val;
    logic [4:0]       cy, cy_nxt, c5, c5_nxt, c1, c1_nxt;
    logic [2:0]       sel, sel_nxt;
    logic [PW-1:0]    pcnt, pcnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             acked, acked_nxt;
    logic             credit;

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    always_comb begin
        coin_val = AMT_W'(1);
        case (sel)
            3'b100:  coin_val = AMT_W'(10);
            3'b010:  coin_val = AMT_W'(5);
            default: coin_val = AMT_W'(1);
        endcase
    end

    // Greedy selection keeps coin_val <= rem, so this never wraps.
    assign rem_sub = rem - coin_val;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        cy_nxt    = cy;
        c5_nxt    = c5;
        c1_nxt    = c1;
        sel_nxt   = sel;
        pcnt_nxt  = pcnt;
        tcnt_nxt  = tcnt;
        acked_nxt = acked;
        credit    = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    rem_nxt   = amount_i;
                    cy_nxt    = '0;
                    c5_nxt    = '0;
                    c1_nxt    = '0;
                    state_nxt = (amount_i == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (rem >= AMT_W'(10))
                    sel_nxt = 3'b100;
                else if (rem >= AMT_W'(5))
                    sel_nxt = 3'b010;
                else
                    sel_nxt = 3'b001;
                pcnt_nxt  = PW'(PULSE_CYC - 1);
                acked_nxt = 1'b0;
                state_nxt = EJECT;
            end
            EJECT: begin
                // An early ack is credited once; the pulse still runs full width.
                if (coin_ack_i && !acked) begin
                    credit    = 1'b1;
                    acked_nxt = 1'b1;
                end
                if (pcnt == '0) begin
                    if (acked || credit) begin
                        state_nxt = ((credit ? rem_sub : rem) == '0) ? DONE : SELECT;
                    end else begin
                        tcnt_nxt  = '0;
                        state_nxt = WAIT_ACK;
                    end
                end else begin
                    pcnt_nxt = pcnt - PW'(1);
                end
            end
            WAIT_ACK: begin
                // An ack on the timeout cycle takes priority over the error.
                if (coin_ack_i) begin
                    credit    = 1'b1;
                    state_nxt = (rem_sub == '0) ? DONE : SELECT;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (credit) begin
            rem_nxt = rem_sub;
            case (sel)
                3'b100:  cy_nxt = sat_inc(cy);
                3'b010:  c5_nxt = sat_inc(c5);
                default: c1_nxt = sat_inc(c1);
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem   <= '0;
            cy    <= '0;
            c5    <= '0;
            c1    <= '0;
            sel   <= '0;
            pcnt  <= '0;
            tcnt  <= '0;
            acked <= 1'b0;
        end else begin
            rem   <= rem_nxt;
            cy    <= cy_nxt;
            c5    <= c5_nxt;
            c1    <= c1_nxt;
            sel   <= sel_nxt;
            pcnt  <= pcnt_nxt;
            tcnt  <= tcnt_nxt;
            acked <= acked_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eject_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            remain_o   <= '0;
            cnt_yuan_o <= '0;
            cnt_5j_o   <= '0;
            cnt_1j_o   <= '0;
        end else begin
            eject_o    <= (state == EJECT) ? sel : 3'b000;
            busy_o     <= (state == SELECT) || (state == EJECT) || (state == WAIT_ACK);
            done_o     <= (state == DONE);
            // SELECT or DONE can only follow an accepted start once ERR has
            // been visited, so reaching either clears the sticky flag.
            err_o      <= (state == ERR) ||
                          (err_o && !((state == SELECT) || (state == DONE)));
            remain_o   <= rem;
            cnt_yuan_o <= cy;
            cnt_5j_o   <= c5;
            cnt_1j_o   <= c1;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam int AMT_W       = 8;
    localparam int PULSE_CYC   = 4;
    localparam int ACK_TIMEOUT = 20;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [AMT_W-1:0] amount_i;
    logic             coin_ack_i;
    logic [2:0]       eject_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [AMT_W-1:0] remain_o;
    logic [4:0]       cnt_yuan_o;
    logic [4:0]       cnt_5j_o;
    logic [4:0]       cnt_1j_o;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .PULSE_CYC  (PULSE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .amount_i  (amount_i),
        .coin_ack_i(coin_ack_i),
        .eject_o   (eject_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .remain_o  (remain_o),
        .cnt_yuan_o(cnt_yuan_o),
        .cnt_5j_o  (cnt_5j_o),
        .cnt_1j_o  (cnt_1j_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] ev [0:31];
    int ncoin, first_rise, fall_cyc, done_cnt, done_cyc, err_cyc, bad_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clk1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input int amt);
        amount_i = AMT_W'(amt);
        start_i  = 1'b1;
        clk1;
        start_i  = 1'b0;
    endtask

    // Follows a payout cycle by cycle, recording eject pulses and acking
    // ack_delay cycles after each pulse falls (-1: never), or in the second
    // cycle of each pulse when ack_mid is set. Stops on done_o or an err_o rise.
    task automatic watch(input int ack_delay, input bit ack_mid, input int budget);
        int cyc = 0;
        int cd = -1;
        int run = 0;
        logic [2:0] prev = 3'b000;
        logic err_prev = err_o;
        bit fin = 1'b0;
        ncoin = 0; first_rise = -1; fall_cyc = -1;
        done_cnt = 0; done_cyc = -1; err_cyc = -1; bad_w = 0;
        while (!fin && cyc < budget) begin
            coin_ack_i = 1'b0;
            if (eject_o != 3'b000) begin
                if (prev == 3'b000) begin
                    if (ncoin < 32) ev[ncoin] = eject_o;
                    ncoin++;
                    run = 0;
                    if (first_rise < 0) first_rise = cyc;
                end
                run++;
                if (ack_mid && run == 2) coin_ack_i = 1'b1;
            end else if (prev != 3'b000) begin
                if (run != PULSE_CYC) bad_w++;
                fall_cyc = cyc;
                cd = ack_delay;
            end
            prev = eject_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (err_o && !err_prev) begin
                err_cyc = cyc;
                fin = 1'b1;
            end
            err_prev = err_o;
            if (!fin) begin
                if (cd == 0) begin
                    coin_ack_i = 1'b1;
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
                clk1;
            end
            cyc++;
        end
        coin_ack_i = 1'b0;
        chk("watch_finished", 32'(fin), 32'd1);
    endtask

    task automatic wait_eject(input string tag, input bit level, input int budget);
        for (int i = 0; i < budget && ((eject_o != 3'b000) != level); i++) clk1;
        chk(tag, 32'(eject_o != 3'b000), 32'(level));
    endtask

    initial begin
        int ycnt;
        rst_i = 1'b1; start_i = 1'b0; amount_i = '0; coin_ack_i = 1'b0;
        clk1;
        clk1;
        rst_i = 1'b0;
        chk("rst_eject", 32'(eject_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_remain", 32'(remain_o), 32'd0);
        chk("rst_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, 32'd0);
        clk1;

        // 16 = 10 + 5 + 1, ack 3 cycles after each pulse falls
        start(16);
        watch(3, 1'b0, 300);
        chk("t1_first_rise", 32'(first_rise), 32'd2);
        chk("t1_ncoin", 32'(ncoin), 32'd3);
        chk("t1_ev0", 32'(ev[0]), 32'b100);
        chk("t1_ev1", 32'(ev[1]), 32'b010);
        chk("t1_ev2", 32'(ev[2]), 32'b001);
        chk("t1_width", 32'(bad_w), 32'd0);
        chk("t1_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, {17'd0, 5'd1, 5'd1, 5'd1});
        chk("t1_remain", 32'(remain_o), 32'd0);
        chk("t1_err", 32'(err_cyc), 32'hffff_ffff);
        clk1;
        chk("t1_done_once", 32'(done_o), 32'd0);
        chk("t1_busy_after", 32'(busy_o), 32'd0);
        clk1;

        // zero amount: straight to DONE
        start(0);
        chk("t2_busy_s0", 32'(busy_o), 32'd0);
        chk("t2_done_s0", 32'(done_o), 32'd0);
        clk1;
        chk("t2_done_s1", 32'(done_o), 32'd1);
        chk("t2_busy_s1", 32'(busy_o), 32'd0);
        chk("t2_eject_s1", 32'(eject_o), 32'd0);
        clk1;
        chk("t2_done_s2", 32'(done_o), 32'd0);
        chk("t2_eject_s2", 32'(eject_o), 32'd0);
        clk1;

        // 255 = 25 yuan + one 5 jiao, immediate acks
        start(255);
        watch(0, 1'b0, 2000);
        ycnt = 0;
        for (int i = 0; i < 25; i++) if (ev[i] == 3'b100) ycnt++;
        chk("t3_ncoin", 32'(ncoin), 32'd26);
        chk("t3_yuan_pulses", 32'(ycnt), 32'd25);
        chk("t3_last", 32'(ev[25]), 32'b010);
        chk("t3_width", 32'(bad_w), 32'd0);
        chk("t3_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, {17'd0, 5'd25, 5'd1, 5'd0});
        chk("t3_remain", 32'(remain_o), 32'd0);
        clk1;
        chk("t3_done_once", 32'(done_o), 32'd0);
        clk1;

        // 7, no acks: timeout after one 5-jiao pulse
        start(7);
        watch(-1, 1'b0, 300);
        chk("t4_ncoin", 32'(ncoin), 32'd1);
        chk("t4_ev0", 32'(ev[0]), 32'b010);
        chk("t4_err_delay", 32'(err_cyc - fall_cyc), 32'd20);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
        chk("t4_remain", 32'(remain_o), 32'd7);
        chk("t4_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, 32'd0);
        chk("t4_busy", 32'(busy_o), 32'd0);
        start(1);
        clk1;
        chk("t4_err_cleared", 32'(err_o), 32'd0);
        watch(0, 1'b0, 300);
        chk("t4_retry_ev0", 32'(ev[0]), 32'b001);
        chk("t4_retry_done", 32'(done_cnt), 32'd1);
        chk("t4_retry_1j", 32'(cnt_1j_o), 32'd1);
        clk1;

        // 13 with an ignored second start, then reset mid-pulse
        start(13);
        clk1;
        chk("t5_busy", 32'(busy_o), 32'd1);
        amount_i = AMT_W'(40);
        start_i  = 1'b1;
        clk1;
        start_i  = 1'b0;
        chk("t5_ev0", 32'(eject_o), 32'b100);
        wait_eject("t5_fall", 1'b0, 20);
        coin_ack_i = 1'b1;
        clk1;
        coin_ack_i = 1'b0;
        wait_eject("t5_rise2", 1'b1, 20);
        chk("t5_ev1", 32'(eject_o), 32'b001);
        chk("t5_remain", 32'(remain_o), 32'd3);
        rst_i = 1'b1;
        clk1;
        rst_i = 1'b0;
        chk("t5_rst_eject", 32'(eject_o), 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_remain", 32'(remain_o), 32'd0);
        chk("t5_rst_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, 32'd0);
        clk1;
        clk1;
        clk1;
        chk("t5_idle", {28'd0, eject_o, busy_o | done_o | err_o}, 32'd0);
        start(6);
        watch(2, 1'b0, 300);
        chk("t5_ncoin", 32'(ncoin), 32'd2);
        chk("t5_new_ev0", 32'(ev[0]), 32'b010);
        chk("t5_new_ev1", 32'(ev[1]), 32'b001);
        chk("t5_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, {17'd0, 5'd0, 5'd1, 5'd1});
        clk1;

        // 5 with the ack arriving inside the eject pulse
        start(5);
        watch(-1, 1'b1, 300);
        chk("t6_ncoin", 32'(ncoin), 32'd1);
        chk("t6_ev0", 32'(ev[0]), 32'b010);
        chk("t6_width", 32'(bad_w), 32'd0);
        chk("t6_done_cyc", 32'(done_cyc), 32'd6);
        chk("t6_counts", {17'd0, cnt_yuan_o, cnt_5j_o, cnt_1j_o}, {17'd0, 5'd0, 5'd1, 5'd0});
        chk("t6_remain", 32'(remain_o), 32'd0);
        chk("t6_err", 32'(err_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
